// File: rtl/sram_pass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_pass_arbiter
// Purpose  : Shares the single-port T SRAM between the read and write
//            requesters of one processing pass. Both walk 0..len-1. A write
//            is only eligible for an address that has already been read.
//            Round-robin arbitration is used when both requesters ask.
// Revision : 1.0 - initial release
// ============================================================================
module sram_pass_arbiter #(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_t_words,
    input  logic              i_rd_req,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [WORD_W-1:0] o_rd_data,
    input  logic              i_wr_req,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic              o_wr_gnt,
    output logic              o_sram_en,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [WORD_W-1:0] o_sram_wdata,
    input  logic [WORD_W-1:0] i_sram_rdata,
    output logic              o_busy,
    output logic              o_pass_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic GNT_RD = 1'b0;
    localparam logic GNT_WR = 1'b1;

    localparam logic [ADDR_W:0] C_CNT_ONE = (ADDR_W+1)'(1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, rd_cnt_q, wr_cnt_q;
    logic              last_gnt_q;

    logic              w_rd_ok, w_wr_ok;
    logic              w_gnt_rd, w_gnt_wr;
    logic              w_last_wr;
    logic              w_zero_start;

    logic              sram_en_q, sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [WORD_W-1:0] sram_wdata_q;
    logic              rd_p1_q, rd_valid_q;
    logic              pass_done_q, busy_q;

    // The accepted write is the last of the pass when it targets len-1.
    assign w_last_wr    = ((wr_cnt_q + C_CNT_ONE) == len_q);
    // A zero-length start completes immediately without entering RUN.
    assign w_zero_start = (state_q == S_IDLE) && i_start && (i_t_words == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start a non-empty pass, leave on the final write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start && (i_t_words != '0)) state_d = S_RUN;
            S_RUN:  if (w_gnt_wr && w_last_wr)       state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: eligibility and round-robin grant, suppressed in reset.
    always_comb begin
        w_rd_ok  = 1'b0;
        w_wr_ok  = 1'b0;
        w_gnt_rd = 1'b0;
        w_gnt_wr = 1'b0;
        if (!rst && (state_q == S_RUN)) begin
            w_rd_ok  = i_rd_req && (rd_cnt_q < len_q);
            w_wr_ok  = i_wr_req && (wr_cnt_q < rd_cnt_q);
            w_gnt_rd = w_rd_ok && (!w_wr_ok || (last_gnt_q == GNT_WR));
            w_gnt_wr = w_wr_ok && (!w_rd_ok || (last_gnt_q == GNT_RD));
        end
    end

    // Pass length, read/write pointers and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            last_gnt_q <= GNT_WR;
        end else begin
            if ((state_q == S_IDLE) && i_start) begin
                len_q    <= i_t_words;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
            end
            if (w_gnt_rd) begin
                rd_cnt_q   <= rd_cnt_q + C_CNT_ONE;
                last_gnt_q <= GNT_RD;
            end
            if (w_gnt_wr) begin
                wr_cnt_q   <= wr_cnt_q + C_CNT_ONE;
                last_gnt_q <= GNT_WR;
            end
        end
    end

    // SRAM command register; we/addr/wdata hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            sram_en_q <= w_gnt_rd || w_gnt_wr;
            if (w_gnt_rd) begin
                sram_we_q   <= 1'b0;
                sram_addr_q <= rd_cnt_q[ADDR_W-1:0];
            end else if (w_gnt_wr) begin
                sram_we_q    <= 1'b1;
                sram_addr_q  <= wr_cnt_q[ADDR_W-1:0];
                sram_wdata_q <= i_wr_data;
            end
        end
    end

    // Read-valid pipeline matches the one-cycle SRAM latency; status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p1_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            pass_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_p1_q     <= w_gnt_rd;
            rd_valid_q  <= rd_p1_q;
            pass_done_q <= w_zero_start || (w_gnt_wr && w_last_wr);
            busy_q      <= (state_d == S_RUN);
        end
    end

    assign o_rd_gnt     = w_gnt_rd;
    assign o_wr_gnt     = w_gnt_wr;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = i_sram_rdata;
    assign o_sram_en    = sram_en_q;
    assign o_sram_we    = sram_we_q;
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_busy       = busy_q;
    assign o_pass_done  = pass_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_pass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_pass_arbiter
// Purpose  : Randomized bench for sram_pass_arbiter with a pass-level
//            reference model and queue-based scoreboard for SRAM commands
//            and returned read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_pass_arbiter;

    localparam int WORD_W = 64;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W:0]   i_t_words;
    logic              i_rd_req;
    logic              o_rd_gnt;
    logic              o_rd_valid;
    logic [WORD_W-1:0] o_rd_data;
    logic              i_wr_req;
    logic [WORD_W-1:0] i_wr_data;
    logic              o_wr_gnt;
    logic              o_sram_en;
    logic              o_sram_we;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [WORD_W-1:0] o_sram_wdata;
    logic [WORD_W-1:0] i_sram_rdata;
    logic              o_busy;
    logic              o_pass_done;

    always #5 clk = ~clk;

    sram_pass_arbiter #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_t_words(i_t_words),
        .i_rd_req(i_rd_req), .o_rd_gnt(o_rd_gnt), .o_rd_valid(o_rd_valid),
        .o_rd_data(o_rd_data), .i_wr_req(i_wr_req), .i_wr_data(i_wr_data),
        .o_wr_gnt(o_wr_gnt), .o_sram_en(o_sram_en), .o_sram_we(o_sram_we),
        .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
        .i_sram_rdata(i_sram_rdata), .o_busy(o_busy), .o_pass_done(o_pass_done)
    );

    // Environment SRAM: one-cycle read latency.
    logic [WORD_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (o_sram_en === 1'b1) begin
            if (o_sram_we) mem[o_sram_addr] <= o_sram_wdata;
            else           i_sram_rdata     <= mem[o_sram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit we; int addr; logic [WORD_W-1:0] d; } sram_t;
    typedef struct { int cyc; logic [WORD_W-1:0] d; } rd_t;
    sram_t sq[$];
    rd_t   rdq[$];

    // Reference model: pass-level view of the arbiter.
    logic [WORD_W-1:0] exp_mem [DEPTH];
    int m_state, m_len, m_rd, m_wr;
    bit m_last_wr, m_done;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event expected none/other (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard monitor on the falling edge.
    always @(negedge clk) begin
        if (o_sram_en === 1'b1) begin
            if (sq.size() == 0) fail("sram_unexpected");
            else begin
                sram_t e;
                e = sq.pop_front();
                check("sram_cyc",  cyc,         e.cyc);
                check("sram_we",   o_sram_we,   e.we);
                check("sram_addr", o_sram_addr, e.addr);
                if (e.we) check("sram_wdata", o_sram_wdata, e.d);
            end
        end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
            fail("sram_missing");
            void'(sq.pop_front());
        end
        if (o_rd_valid === 1'b1) begin
            if (rdq.size() == 0) fail("rd_valid_unexpected");
            else begin
                rd_t r;
                r = rdq.pop_front();
                check("rd_cyc",  cyc,       r.cyc);
                check("rd_data", o_rd_data, r.d);
            end
        end else if (o_rd_valid !== 1'b0) begin
            check("rd_valid_known", o_rd_valid, 0);
        end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
            fail("rd_valid_missing");
            void'(rdq.pop_front());
        end
    end

    // One clock cycle: predict grants from the current inputs, compare, advance.
    task automatic tick();
        bit rok, wok, eg_rd, eg_wr;
        int a;
        #1;
        eg_rd = 1'b0;
        eg_wr = 1'b0;
        if (!rst && m_state == 1) begin
            rok = i_rd_req && (m_rd < m_len);
            wok = i_wr_req && (m_wr < m_rd);
            if (rok && wok) begin
                eg_rd = m_last_wr;
                eg_wr = !m_last_wr;
            end else begin
                eg_rd = rok;
                eg_wr = wok;
            end
        end
        check("rd_gnt",    o_rd_gnt,    eg_rd);
        check("wr_gnt",    o_wr_gnt,    eg_wr);
        check("pass_done", o_pass_done, m_done);
        check("busy",      o_busy,      (m_state == 1));
        if (rst) begin
            m_state = 0; m_len = 0; m_rd = 0; m_wr = 0;
            m_last_wr = 1'b1; m_done = 1'b0;
            rdq.delete();
            sq.delete();
        end else begin
            m_done = 1'b0;
            if (m_state == 0) begin
                if (i_start) begin
                    if (i_t_words == 0) m_done = 1'b1;
                    else begin
                        m_state = 1; m_len = int'(i_t_words); m_rd = 0; m_wr = 0;
                    end
                end
            end else begin
                if (eg_rd) begin
                    a = m_rd % DEPTH;
                    sq.push_back('{cyc + 1, 1'b0, a, 64'd0});
                    rdq.push_back('{cyc + 2, exp_mem[a]});
                    m_rd++;
                    m_last_wr = 1'b0;
                end
                if (eg_wr) begin
                    a = m_wr % DEPTH;
                    sq.push_back('{cyc + 1, 1'b1, a, i_wr_data});
                    exp_mem[a] = i_wr_data;
                    m_wr++;
                    m_last_wr = 1'b1;
                    if (m_wr == m_len) begin
                        m_state = 0;
                        m_done  = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic start_pass(input int len, input bit rd, input bit wr);
        i_start   = 1'b1;
        i_t_words = (ADDR_W+1)'(len);
        i_rd_req  = rd;
        i_wr_req  = wr;
        i_wr_data = {$urandom, $urandom};
        tick();
        i_start = 1'b0;
    endtask

    // Random requests (percent probabilities) until the model says the pass ended.
    task automatic run_pass(input int prd, input int pwr, input int maxc);
        int n = 0;
        while (m_state == 1 && n < maxc) begin
            i_rd_req  = ($urandom_range(99) < prd);
            i_wr_req  = ($urandom_range(99) < pwr);
            i_wr_data = {$urandom, $urandom};
            i_start   = $urandom_range(1);
            i_t_words = (ADDR_W+1)'($urandom_range(0, DEPTH));
            tick();
            n++;
        end
        if (m_state == 1) fail("pass_timeout");
        i_start  = 1'b0;
        i_rd_req = 1'b0;
        i_wr_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [WORD_W-1:0] v;
            v = {$urandom, $urandom};
            mem[i]     = v;
            exp_mem[i] = v;
        end
        rst = 1'b1; i_start = 1'b0; i_t_words = '0;
        i_rd_req = 1'b0; i_wr_req = 1'b0; i_wr_data = '0;
        m_state = 0; m_len = 0; m_rd = 0; m_wr = 0; m_last_wr = 1'b1; m_done = 1'b0;
        @(negedge clk);

        // T1: reset with random inputs, then a read request without start.
        for (int i = 0; i < 2; i++) begin
            i_start   = $urandom_range(1);
            i_rd_req  = $urandom_range(1);
            i_wr_req  = $urandom_range(1);
            i_t_words = (ADDR_W+1)'($urandom_range(0, DEPTH));
            tick();
        end
        rst = 1'b0; i_start = 1'b0; i_rd_req = 1'b1; i_wr_req = 1'b0;
        repeat (3) tick();

        // T2: read-only stretch of a 4-word pass, then drain the writes.
        start_pass(4, 1'b1, 1'b0);
        repeat (5) tick();
        run_pass(0, 100, 50);

        // T3: both requesters held high over 8 words.
        start_pass(8, 1'b1, 1'b1);
        run_pass(100, 100, 100);

        // T4: write requester always asking, reads sporadic.
        start_pass(4, 1'b0, 1'b1);
        run_pass(30, 100, 300);

        // T5: zero-length pass.
        start_pass(0, 1'b1, 1'b1);
        i_rd_req = 1'b0; i_wr_req = 1'b0;
        repeat (3) tick();

        // T6: abort mid-pass, then a full-size pass.
        start_pass(16, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            i_rd_req  = $urandom_range(1);
            i_wr_req  = $urandom_range(1);
            i_wr_data = {$urandom, $urandom};
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; i_rd_req = 1'b1; i_wr_req = 1'b1;
        repeat (2) tick();
        start_pass(DEPTH, 1'b1, 1'b1);
        run_pass(100, 100, 2 * DEPTH + 20);

        // Random short passes with random request patterns.
        for (int p = 0; p < 8; p++) begin
            start_pass($urandom_range(1, 40), 1'b0, 1'b0);
            run_pass($urandom_range(20, 90), $urandom_range(20, 90), 600);
        end

        repeat (4) tick();
        check("sram_queue_drained", sq.size(), 0);
        check("rd_queue_drained",   rdq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
